// File: rtl/circuito_exp4_desafio_pkg.sv
// Shared definitions for the sequence-memory game: state codes, sequence ROM
// and the active-low seven-segment encoding used by the debug displays.
package circuito_exp4_desafio_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_ERRO   = 4'hE
    } estado_t;

    // Address 0 sits in the least-significant nibble.
    localparam logic [63:0] ROM_DADOS = 64'h4188_4422_1124_8421;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    function automatic logic [3:0] rom_ler(input logic [3:0] endereco);
        return ROM_DADOS[{endereco, 2'b00} +: 4];
    endfunction

    // Bit order {g,f,e,d,c,b,a}, segment lit when 0.
    function automatic logic [6:0] hex_para_7seg(input logic [3:0] valor);
        logic [6:0] seg;
        case (valor)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/circuito_exp4_desafio_hexa7seg.sv
// Hex digit to active-low seven-segment decoder for the lab board displays.
module hexa7seg
    import circuito_exp4_desafio_pkg::*;
(
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    assign display = hex_para_7seg(hexa);

endmodule

// File: rtl/circuito_exp4_desafio.sv
// Sequence-memory game: control unit plus datapath comparing chaves against a ROM.
// Debug displays are enabled by defining CIRCUITO_EXP4_DEBUG_EN; otherwise blanked.
module circuito_exp4_desafio
    import circuito_exp4_desafio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    estado_t    estado, proximo_estado;
    logic [3:0] contagem;
    logic [3:0] chaves_reg;
    logic [3:0] memoria;
    logic       igual;
    logic       fim;
    logic       zera_c, conta_c, carrega_c;

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo_estado;
    end

    always_ff @(posedge clock) begin
        if (reset || zera_c)  contagem <= '0;
        else if (conta_c)     contagem <= contagem + 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset || zera_c)  chaves_reg <= '0;
        else if (carrega_c)   chaves_reg <= chaves;
    end

    assign memoria = rom_ler(contagem);
    assign igual   = (chaves_reg == memoria);
    assign fim     = (contagem == 4'hF);

    always_comb begin
        proximo_estado = estado;
        zera_c         = 1'b0;
        conta_c        = 1'b0;
        carrega_c      = 1'b0;
        case (estado)
            INICIAL:    if (iniciar) proximo_estado = PREPARACAO;
            PREPARACAO: begin
                zera_c         = 1'b1;
                proximo_estado = REGISTRA;
            end
            REGISTRA: begin
                carrega_c      = 1'b1;
                proximo_estado = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)   proximo_estado = FIM_ERRO;
                else if (fim) proximo_estado = FIM_ACERTO;
                else          proximo_estado = PROXIMO;
            end
            PROXIMO: begin
                conta_c        = 1'b1;
                proximo_estado = REGISTRA;
            end
            FIM_ACERTO, FIM_ERRO: if (iniciar) proximo_estado = PREPARACAO;
            default:    proximo_estado = INICIAL;
        endcase
        // A restart also clears on entry so the displays read 0 while preparing.
        if (proximo_estado == PREPARACAO) zera_c = 1'b1;
    end

    assign pronto  = (estado == FIM_ACERTO) || (estado == FIM_ERRO);
    assign acertou = (estado == FIM_ACERTO);
    assign errou   = (estado == FIM_ERRO);

`ifdef CIRCUITO_EXP4_DEBUG_EN
    assign db_igual   = igual;
    assign db_iniciar = iniciar;

    hexa7seg u_hex_contagem (.hexa(contagem),   .display(db_contagem));
    hexa7seg u_hex_memoria  (.hexa(memoria),    .display(db_memoria));
    hexa7seg u_hex_chaves   (.hexa(chaves_reg), .display(db_chaves));
    hexa7seg u_hex_estado   (.hexa(estado),     .display(db_estado));
`else
    assign db_igual    = 1'b0;
    assign db_iniciar  = 1'b0;
    assign db_contagem = SEG_APAGADO;
    assign db_memoria  = SEG_APAGADO;
    assign db_chaves   = SEG_APAGADO;
    assign db_estado   = SEG_APAGADO;
`endif

endmodule

// File: tb/tb_circuito_exp4_desafio.sv
// Scoreboard bench for the sequence-memory game: stimulus queues expected
// snapshots tagged with a cycle number, a monitor compares them on the falling edge.
module tb_circuito_exp4_desafio;

    logic       clock = 1'b0;
    logic       reset, iniciar;
    logic [3:0] chaves;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    circuito_exp4_desafio dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_igual(db_igual), .db_iniciar(db_iniciar),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_chaves(db_chaves), .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                             4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    typedef struct {
        int         cyc;
        logic [2:0] flags;   // {pronto, acertou, errou}
        logic [6:0] estado, contagem, memoria, chv;
        logic       igual, inic;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    total = 0;
    int    passed = 0;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] dbg_seg(input logic [3:0] v);
`ifdef CIRCUITO_EXP4_DEBUG_EN
        return seg(v);
`else
        return 7'b1111111;
`endif
    endfunction

    function automatic logic dbg_bit(input logic b);
`ifdef CIRCUITO_EXP4_DEBUG_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_now(input string name, input logic [2:0] flags,
                              input logic [3:0] st, input logic [3:0] ct,
                              input logic [3:0] mem, input logic [3:0] chv,
                              input logic ig, input logic ini);
        exp_t e;
        e.cyc      = cyc;
        e.flags    = flags;
        e.estado   = dbg_seg(st);
        e.contagem = dbg_seg(ct);
        e.memoria  = dbg_seg(mem);
        e.chv      = dbg_seg(chv);
        e.igual    = dbg_bit(ig);
        e.inic     = dbg_bit(ini);
        q.push_back(e);
        qn.push_back(name);
    endtask

    task automatic chk(input string name, input string field,
                       input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got %b expected %b (t=%0t)", name, field, act, exp, $time);
    endtask

    exp_t  me;
    string mn;
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            mn = qn.pop_front();
            if (me.cyc < cyc) begin
                total++;
                $display("FAIL %s: checked at cycle %0d expected cycle %0d", mn, cyc, me.cyc);
            end else begin
                chk(mn, "pronto",      {6'b0, pronto},     {6'b0, me.flags[2]});
                chk(mn, "acertou",     {6'b0, acertou},    {6'b0, me.flags[1]});
                chk(mn, "errou",       {6'b0, errou},      {6'b0, me.flags[0]});
                chk(mn, "db_estado",   db_estado,          me.estado);
                chk(mn, "db_contagem", db_contagem,        me.contagem);
                chk(mn, "db_memoria",  db_memoria,         me.memoria);
                chk(mn, "db_chaves",   db_chaves,          me.chv);
                chk(mn, "db_igual",    {6'b0, db_igual},   {6'b0, me.igual});
                chk(mn, "db_iniciar",  {6'b0, db_iniciar}, {6'b0, me.inic});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
        step(); step();
        reset = 1'b0;
    endtask

    // Starts from inicial or an end state; returns in registra at address 0.
    task automatic start_game();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
    endtask

    // Correct entry at address a; returns in registra at a+1 (or fim_acerto at 15).
    task automatic round_ok(input int a);
        chaves = rom[a];
        step();
        expect_now($sformatf("cmp_a%0d", a), 3'b000, 4'h5, 4'(a), rom[a], rom[a], 1'b1, 1'b0);
        step();
        if (a < 15) begin
            expect_now($sformatf("prox_a%0d", a), 3'b000, 4'h6, 4'(a), rom[a], rom[a], 1'b1, 1'b0);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        expect_now("reset", 3'b000, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);

        // Full success run; chaves changes every 3 cycles.
        iniciar = 1'b1;
        expect_now("db_iniciar", 3'b000, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1);
        step();
        iniciar = 1'b0;
        expect_now("prep", 3'b000, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        step();
        expect_now("registra0", 3'b000, 4'h4, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) round_ok(a);
        expect_now("acerto", 3'b110, 4'hA, 4'hF, 4'h4, 4'h4, 1'b1, 1'b0);
        step(); step();
        expect_now("acerto_hold", 3'b110, 4'hA, 4'hF, 4'h4, 4'h4, 1'b1, 1'b0);

        // Mismatch at address 4: entering 2 where ROM holds 4.
        do_reset();
        start_game();
        for (int a = 0; a < 4; a++) round_ok(a);
        chaves = 4'h2;
        step();
        expect_now("cmp_err", 3'b000, 4'h5, 4'h4, 4'h4, 4'h2, 1'b0, 1'b0);
        step();
        expect_now("erro", 3'b101, 4'hE, 4'h4, 4'h4, 4'h2, 1'b0, 1'b0);

        // Restart from fim_erro.
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        expect_now("restart_prep", 3'b000, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        step();
        round_ok(0);
        expect_now("restart_adv", 3'b000, 4'h4, 4'h1, 4'h2, 4'h1, 1'b0, 1'b0);

        // Reset during round 7 abandons the game silently.
        do_reset();
        start_game();
        for (int a = 0; a < 7; a++) round_ok(a);
        chaves = rom[7];
        step();
        expect_now("r7_cmp", 3'b000, 4'h5, 4'h7, 4'h1, 4'h1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_now("midreset", 3'b000, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
        step(); step();
        expect_now("idle", 3'b000, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);

        // Wrong first entry: 0010 against ROM 0001 at address 0.
        start_game();
        chaves = 4'h2;
        step();
        expect_now("cmp_a0_wrong", 3'b000, 4'h5, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0);
        step();
        expect_now("erro_a0", 3'b101, 4'hE, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0);

        step(); step();
        while (q.size() > 0) begin
            total++;
            $display("FAIL %s: expectation never checked (cycle %0d)", qn[0], q[0].cyc);
            void'(q.pop_front());
            void'(qn.pop_front());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
